// File: rtl/complex_acc.sv
// Complex accumulator: sums acc_len consecutive complex products and holds the sum on a valid/ready output.
// Optional macro COMPLEX_ACC_SAT_EN selects per-part saturation with a sticky acc_ovf flag (default: wrap, acc_ovf=0).
module complex_acc #(
  parameter int RES_WIDTH = 17,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sw_rst,
  input  logic        [CNT_WIDTH-1:0] acc_len,
  input  logic                        res_val,
  output logic                        res_ready,
  input  logic signed [RES_WIDTH-1:0] res_re,
  input  logic signed [RES_WIDTH-1:0] res_im,
  output logic                        acc_val,
  input  logic                        acc_ready,
  output logic signed [ACC_WIDTH-1:0] acc_re,
  output logic signed [ACC_WIDTH-1:0] acc_im,
  output logic                        acc_ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic                        res_ready_q, res_ready_d;
  logic                        acc_val_q, acc_val_d;
  logic signed [ACC_WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic        [CNT_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic signed [ACC_WIDTH-1:0] smp_re, smp_im;
  logic                        beat;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [RES_WIDTH-1:0] x);
    return ACC_WIDTH'(x);
  endfunction

`ifdef COMPLEX_ACC_SAT_EN
  logic ovf_q, ovf_d;

  function automatic logic ovf_chk(input logic signed [ACC_WIDTH-1:0] a,
                                   input logic signed [ACC_WIDTH-1:0] b);
    logic signed [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    return s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
  endfunction

  // One guard bit is enough: the sign of the wide sum picks the clamp direction.
  function automatic logic signed [ACC_WIDTH-1:0] add_part(input logic signed [ACC_WIDTH-1:0] a,
                                                           input logic signed [ACC_WIDTH-1:0] b);
    logic signed [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return s[ACC_WIDTH-1:0];
  endfunction
`else
  function automatic logic signed [ACC_WIDTH-1:0] add_part(input logic signed [ACC_WIDTH-1:0] a,
                                                           input logic signed [ACC_WIDTH-1:0] b);
    return a + b;
  endfunction
`endif

  assign beat    = res_val && res_ready_q;
  assign smp_re  = sext(res_re);
  assign smp_im  = sext(res_im);
  assign cnt_inc = cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    res_ready_d = res_ready_q;
    acc_val_d   = acc_val_q;
    re_d        = re_q;
    im_d        = im_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
`ifdef COMPLEX_ACC_SAT_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (beat) begin
          len_d = (acc_len == '0) ? CNT_WIDTH'(1) : acc_len;
          re_d  = smp_re;
          im_d  = smp_im;
          cnt_d = CNT_WIDTH'(1);
          if (acc_len <= CNT_WIDTH'(1)) begin
            state_d     = S_HOLD;
            res_ready_d = 1'b0;
            acc_val_d   = 1'b1;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (beat) begin
          re_d  = add_part(re_q, smp_re);
          im_d  = add_part(im_q, smp_im);
`ifdef COMPLEX_ACC_SAT_EN
          ovf_d = ovf_q | ovf_chk(re_q, smp_re) | ovf_chk(im_q, smp_im);
`endif
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d     = S_HOLD;
            res_ready_d = 1'b0;
            acc_val_d   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (acc_ready) begin
          state_d     = S_IDLE;
          res_ready_d = 1'b1;
          acc_val_d   = 1'b0;
          re_d        = '0;
          im_d        = '0;
          cnt_d       = '0;
`ifdef COMPLEX_ACC_SAT_EN
          ovf_d       = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Software reset overrides any handshake seen in the same cycle.
    if (sw_rst) begin
      state_d     = S_IDLE;
      res_ready_d = 1'b1;
      acc_val_d   = 1'b0;
      re_d        = '0;
      im_d        = '0;
      cnt_d       = '0;
      len_d       = '0;
`ifdef COMPLEX_ACC_SAT_EN
      ovf_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      res_ready_q <= 1'b1;
      acc_val_q   <= 1'b0;
      re_q        <= '0;
      im_q        <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      res_ready_q <= res_ready_d;
      acc_val_q   <= acc_val_d;
      re_q        <= re_d;
      im_q        <= im_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
    end
  end

`ifdef COMPLEX_ACC_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign acc_ovf = ovf_q;
`else
  assign acc_ovf = 1'b0;
`endif

  assign res_ready = res_ready_q;
  assign acc_val   = acc_val_q;
  assign acc_re    = re_q;
  assign acc_im    = im_q;

endmodule

// File: tb/tb_complex_acc.sv
// Self-checking bench for complex_acc: directed scenarios plus randomized frames against a queue-based reference sum.
module tb_complex_acc;
  localparam int RW = 17;
  localparam int AW = 24;
  localparam int CW = 8;
  localparam longint MAXV = (64'sd1 <<< (AW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (AW-1));
  localparam longint MODV = 64'sd1 <<< AW;

  logic                 clk = 1'b0;
  logic                 rst, sw_rst;
  logic        [CW-1:0] acc_len;
  logic                 res_val, res_ready;
  logic signed [RW-1:0] res_re, res_im;
  logic                 acc_val, acc_ready;
  logic signed [AW-1:0] acc_re, acc_im;
  logic                 acc_ovf;

  int total  = 0;
  int passed = 0;
  longint bq_re[$];
  longint bq_im[$];

  always #5 clk = ~clk;

  complex_acc #(.RES_WIDTH(RW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .acc_len(acc_len),
    .res_val(res_val), .res_ready(res_ready), .res_re(res_re), .res_im(res_im),
    .acc_val(acc_val), .acc_ready(acc_ready), .acc_re(acc_re), .acc_im(acc_im),
    .acc_ovf(acc_ovf)
  );

  // Reference: one part's running sum, either wrapped modulo 2^AW or clamped to the signed range.
  function automatic longint fold(input longint a, input longint b, inout logic ovf);
    longint s;
    s = a + b;
`ifdef COMPLEX_ACC_SAT_EN
    if (s > MAXV) begin s = MAXV; ovf = 1'b1; end
    else if (s < MINV) begin s = MINV; ovf = 1'b1; end
`else
    while (s > MAXV) s -= MODV;
    while (s < MINV) s += MODV;
`endif
    return s;
  endfunction

  task automatic model_sum(output longint ere, output longint eim, output logic eovf);
    ere = 0; eim = 0; eovf = 1'b0;
    foreach (bq_re[i]) begin
      ere = fold(ere, bq_re[i], eovf);
      eim = fold(eim, bq_im[i], eovf);
    end
  endtask

  // Entered and left at a falling edge; the beat is accepted at the rising edge in between.
  task automatic beat(input longint re, input longint im);
    int n = 0;
    while (!res_ready && n < 50) begin @(negedge clk); n++; end
    if (!res_ready) begin
      total++;
      $display("FAIL beat_timeout: res_ready=%0b required 1", res_ready);
      return;
    end
    res_val = 1'b1;
    res_re  = re[RW-1:0];
    res_im  = im[RW-1:0];
    bq_re.push_back(re);
    bq_im.push_back(im);
    @(negedge clk);
    res_val = 1'b0;
  endtask

  task automatic release_out();
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_rst = 1'b0; acc_len = '0; res_val = 1'b0; res_re = '0; res_im = '0; acc_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({res_ready, acc_val, acc_ovf, acc_re, acc_im} !== {1'b1, 1'b0, 1'b0, 48'd0})
      $display("FAIL reset_state: rdy=%0b val=%0b ovf=%0b re=%0d im=%0d required 1 0 0 0 0",
               res_ready, acc_val, acc_ovf, acc_re, acc_im);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({res_ready, acc_val} !== 2'b10)
      $display("FAIL reset_release: rdy=%0b val=%0b required 1 0", res_ready, acc_val);
    else passed++;
  endtask

  task automatic test_single();
    bq_re.delete(); bq_im.delete();
    acc_len = 8'd1;
    beat(-18, 24);
    total++;
    if ({acc_val, res_ready} !== 2'b10 || acc_re !== -18 || acc_im !== 24)
      $display("FAIL single_sum: val=%0b rdy=%0b re=%0d im=%0d required 1 0 -18 24",
               acc_val, res_ready, acc_re, acc_im);
    else passed++;
    release_out();
    total++;
    if ({acc_val, res_ready, acc_re, acc_im} !== {2'b01, 48'd0})
      $display("FAIL single_idle: val=%0b rdy=%0b re=%0d im=%0d required 0 1 0 0",
               acc_val, res_ready, acc_re, acc_im);
    else passed++;
  endtask

  task automatic test_hold();
    bq_re.delete(); bq_im.delete();
    acc_len = 8'd3;
    beat(-18, 24); beat(5, -3); beat(1, 1);
    total++;
    if (acc_val !== 1'b1 || acc_re !== -12 || acc_im !== 22)
      $display("FAIL hold_sum: val=%0b re=%0d im=%0d required 1 -12 22", acc_val, acc_re, acc_im);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      res_val = 1'b1; res_re = 17'sd100; res_im = 17'sd100;
      @(negedge clk);
      total++;
      if ({acc_val, res_ready} !== 2'b10 || acc_re !== -12 || acc_im !== 22)
        $display("FAIL hold_stable: cyc=%0d val=%0b rdy=%0b re=%0d im=%0d required 1 0 -12 22",
                 c, acc_val, res_ready, acc_re, acc_im);
      else passed++;
    end
    res_val = 1'b0;
    release_out();
  endtask

  task automatic test_gaps();
    bq_re.delete(); bq_im.delete();
    acc_len = 8'd3;
    beat(-18, 24);
    acc_len = 8'd7;
    beat(5, -3);
    repeat (2) @(negedge clk);
    beat(1, 1);
    total++;
    if (acc_val !== 1'b1 || acc_re !== -12 || acc_im !== 22)
      $display("FAIL gaps_sum: val=%0b re=%0d im=%0d required 1 -12 22", acc_val, acc_re, acc_im);
    else passed++;
    repeat (4) @(negedge clk);
    release_out();
  endtask

  task automatic test_len_zero();
    bq_re.delete(); bq_im.delete();
    acc_len = 8'd0;
    beat(7, -9);
    total++;
    if (acc_val !== 1'b1 || acc_re !== 7 || acc_im !== -9)
      $display("FAIL len_zero: val=%0b re=%0d im=%0d required 1 7 -9", acc_val, acc_re, acc_im);
    else passed++;
    release_out();
  endtask

  task automatic test_overflow();
    longint ere, eim, kre;
    logic eovf, kovf;
    bq_re.delete(); bq_im.delete();
    acc_len = 8'd200;
    for (int i = 0; i < 200; i++) beat(65535, 0);
    model_sum(ere, eim, eovf);
`ifdef COMPLEX_ACC_SAT_EN
    kre = 8388607; kovf = 1'b1;
`else
    kre = -3670216; kovf = 1'b0;
`endif
    total++;
    if (acc_val !== 1'b1 || acc_re !== ere || acc_im !== eim || acc_ovf !== eovf)
      $display("FAIL ovf_model: val=%0b re=%0d im=%0d ovf=%0b required 1 %0d %0d %0b",
               acc_val, acc_re, acc_im, acc_ovf, ere, eim, eovf);
    else passed++;
    total++;
    if (acc_re !== kre || acc_im !== 0 || acc_ovf !== kovf)
      $display("FAIL ovf_const: re=%0d im=%0d ovf=%0b required %0d 0 %0b", acc_re, acc_im, acc_ovf, kre, kovf);
    else passed++;
    release_out();
    total++;
    if (acc_ovf !== 1'b0 || acc_val !== 1'b0)
      $display("FAIL ovf_clear: ovf=%0b val=%0b required 0 0", acc_ovf, acc_val);
    else passed++;
  endtask

  task automatic test_resets();
    bq_re.delete(); bq_im.delete();
    acc_len = 8'd4;
    beat(10, 20); beat(30, 40);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({res_ready, acc_val, acc_re, acc_im} !== {2'b10, 48'd0})
      $display("FAIL async_rst: rdy=%0b val=%0b re=%0d im=%0d required 1 0 0 0", res_ready, acc_val, acc_re, acc_im);
    else passed++;
    #1 rst = 1'b0;
    @(negedge clk);
    bq_re.delete(); bq_im.delete();
    acc_len = 8'd1;
    beat(3, 3);
    total++;
    if (acc_val !== 1'b1 || acc_re !== 3 || acc_im !== 3)
      $display("FAIL after_rst: val=%0b re=%0d im=%0d required 1 3 3", acc_val, acc_re, acc_im);
    else passed++;
    release_out();

    bq_re.delete(); bq_im.delete();
    acc_len = 8'd4;
    beat(10, 20); beat(30, 40);
    sw_rst = 1'b1; res_val = 1'b1; res_re = 17'sd5; res_im = 17'sd5;
    @(negedge clk);
    sw_rst = 1'b0; res_val = 1'b0;
    total++;
    if ({res_ready, acc_val, acc_re, acc_im} !== {2'b10, 48'd0})
      $display("FAIL sw_rst: rdy=%0b val=%0b re=%0d im=%0d required 1 0 0 0", res_ready, acc_val, acc_re, acc_im);
    else passed++;
    bq_re.delete(); bq_im.delete();
    acc_len = 8'd1;
    beat(3, 3);
    total++;
    if (acc_val !== 1'b1 || acc_re !== 3 || acc_im !== 3)
      $display("FAIL after_sw_rst: val=%0b re=%0d im=%0d required 1 3 3", acc_val, acc_re, acc_im);
    else passed++;
    release_out();
  endtask

  task automatic test_random();
    longint ere, eim;
    logic eovf;
    int len;
    for (int f = 0; f < 8; f++) begin
      bq_re.delete(); bq_im.delete();
      len = $urandom_range(1, 6);
      acc_len = CW'(len);
      for (int b = 0; b < len; b++) begin
        if (b > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
        beat(longint'($urandom_range(0, 131071)) - 65536, longint'($urandom_range(0, 131071)) - 65536);
        if (b == 0) acc_len = CW'($urandom_range(0, 255));
      end
      model_sum(ere, eim, eovf);
      total++;
      if (acc_val !== 1'b1 || acc_re !== ere || acc_im !== eim || acc_ovf !== eovf)
        $display("FAIL random_frame%0d: val=%0b re=%0d im=%0d ovf=%0b required 1 %0d %0d %0b",
                 f, acc_val, acc_re, acc_im, acc_ovf, ere, eim, eovf);
      else passed++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_gaps();
    test_len_zero();
    test_overflow();
    test_resets();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/complex_acc.md
Name: complex_acc

Overview:
Downstream consumer of the complex number multiplier. Accepts product results over the res_val/res_ready handshake and sums a programmable number of consecutive products, producing a complex dot product. Presents the sum on a valid/ready output handshake to the next stage, for example a result collector or bus interface.

Parameters:
RES_WIDTH, 17, width of each signed (two's complement) product part from the multiplier (2*DATA_WIDTH+1 for DATA_WIDTH=8)
ACC_WIDTH, 24, width of each signed accumulator part; must be >= RES_WIDTH
CNT_WIDTH, 8, width of the length field and beat counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous reset, active-high
sw_rst  input  1  synchronous software reset, active-high
acc_len  input  CNT_WIDTH  number of products per sum; sampled on first beat of a frame
res_val  input  1  product valid (from multiplier)
res_ready  output  1  accumulator can take a product
res_re  input  RES_WIDTH  product real part, signed
res_im  input  RES_WIDTH  product imaginary part, signed
acc_val  output  1  sum valid
acc_ready  input  1  consumer accepts sum
acc_re  output  ACC_WIDTH  sum real part, signed
acc_im  output  ACC_WIDTH  sum imaginary part, signed
acc_ovf  output  1  overflow flag (see Optional Feature)

Behaviour:
- Reset (rst asserted, or sw_rst sampled high): state IDLE, res_ready=1, acc_val=0, acc_re=acc_im=0, acc_ovf=0, counter=0, latched length=0. sw_rst takes priority over every handshake in the same cycle.
- Reset mid-frame discards the partial sum. No output is produced for that frame.
- All outputs are registered.
- Beat transfer: res_val && res_ready at a rising edge. Output transfer: acc_val && acc_ready at a rising edge.
- Input is sign-extended from RES_WIDTH to ACC_WIDTH before addition. Real and imaginary parts are independent adders.
- States:
  - IDLE: res_ready=1. On a beat, latch L = acc_len (L=0 is treated as 1), acc <= sample, cnt <= 1. If L==1, go to HOLD; else go to ACCUM.
  - ACCUM: res_ready=1. On a beat, acc <= acc + sample, cnt <= cnt+1. If cnt+1 == L, go to HOLD. Without a beat, hold state.
  - HOLD: res_ready=0, acc_val=1, acc_re/acc_im stable. On output transfer: acc_val<=0, acc cleared, acc_ovf cleared, res_ready<=1, go to IDLE.
- Latency: acc_val rises on the same edge that accepts the last beat. Concretely, res_ready falls and acc_val rises in the cycle after that edge's sampling. Minimum frame-to-frame gap: 1 cycle (the HOLD cycle).
- acc_len changes mid-frame are ignored. The latched L governs the frame.
- Gaps in res_val are tolerated with no loss. acc_ready may be held low indefinitely; the sum stays stable while it is low.
- acc_ready asserted while acc_val=0 has no effect.
- Default overflow behaviour is two's-complement wrap modulo 2^ACC_WIDTH, and acc_ovf stays 0.

Optional Feature:
Macro COMPLEX_ACC_SAT_EN.
- Defined: each part saturates independently. A positive overflow clamps to 2^(ACC_WIDTH-1)-1; a negative overflow clamps to -2^(ACC_WIDTH-1). Once clamped, later additions continue from the clamped value.
- Defined: acc_ovf is set sticky for the frame on any clamp, is valid with acc_val, and clears on output transfer or reset.
- Not defined: wrap arithmetic; acc_ovf is tied to 0 and no saturation logic is built.

Test Plan:
1. acc_len=1, one beat -18+24i (product of (2+4i)(3+6i)) -> acc_val=1 next cycle, acc_re=-18, acc_im=24, res_ready=0 until acc_ready. Return to IDLE one cycle after the output transfer.
2. acc_len=3, beats -18+24i, 5-3i, 1+1i with acc_ready=0 for 5 cycles after acc_val -> acc_re=-12, acc_im=22. Values stable and res_ready=0 throughout the hold. Extra res_val pulses are not accepted.
3. Same frame as test 2 with res_val gaps of 0, 2, 4 cycles, and acc_len changed to 7 after the first beat -> identical result -12+22i after exactly 3 beats.
4. acc_len=0, one beat 7-9i -> behaves as length 1, acc=7-9i.
5. acc_len=200, every beat 65535+0i:
   - Wrap build: acc_re=-3670216 (13107000 - 2^24), acc_ovf=0.
   - COMPLEX_ACC_SAT_EN build: acc_re=8388607, acc_ovf=1.
   - acc_im=0 in both builds.
6. acc_len=4, rst pulsed asynchronously after 2 beats (repeat with sw_rst) -> outputs 0 and res_ready=1 immediately after reset. A following 1-beat frame 3+3i yields exactly 3+3i.
